// File: rtl/dcache_nway_wb_if.sv
// ---------------------------------------------------------------------------
// dcache_nway_wb_if
// Bundles every non-clock/non-reset signal of the write-back data cache into
// one interface: the CPU-side load/store handshake, the flush handshake and
// the single-outstanding line-wide memory port.
//
// Ports / signals:
//   req_valid, req_write, req_addr, req_wdata, req_funct3 : CPU request
//   req_ready                                             : cache can accept
//   resp_valid, resp_rdata                                : load/store result
//   flush_req, flush_done                                 : flush handshake
//   mem_req_valid, mem_req_write, mem_addr, mem_wdata     : memory request
//   mem_ready, mem_rdata                                  : memory answer
//
// Modports:
//   master : the environment (CPU plus memory) that talks to the cache
//   slave  : the cache itself
// ---------------------------------------------------------------------------
interface dcache_nway_wb_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 128
);
    logic                 req_valid;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [31:0]          req_wdata;
    logic [2:0]           req_funct3;
    logic                 req_ready;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 flush_req;
    logic                 flush_done;
    logic                 mem_req_valid;
    logic                 mem_req_write;
    logic [ADDR_W-1:0]    mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic                 mem_ready;
    logic [LINE_BITS-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        output flush_req, mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, flush_done,
        input  mem_req_valid, mem_req_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  flush_req, mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, flush_done,
        output mem_req_valid, mem_req_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_nway_wb.sv
// ---------------------------------------------------------------------------
// dcache_nway_wb
// N-way set-associative, write-back / write-allocate data cache for the MEM
// stage. Serves B/H/W loads (signed and unsigned) and stores, fills and evicts
// whole lines over a single-outstanding memory port, replaces victims with a
// per-set round-robin pointer (invalid ways first) and can flush the whole
// cache (write back dirty lines, invalidate everything).
//
// Ports:
//   clk      : clock
//   reset_n  : synchronous reset, active low
//   bus      : dcache_nway_wb_if.slave (CPU request/response, flush, memory)
// ---------------------------------------------------------------------------
module dcache_nway_wb #(
    parameter int LINE_BITS = 128,
    parameter int NUM_SETS  = 4,
    parameter int NUM_WAYS  = 4,
    parameter int ADDR_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    dcache_nway_wb_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {IDLE, WRITEBACK, FILL, RESPOND, FLUSH} state_t;

    state_t               state;
    state_t               state_next;

    logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
    logic [WAY_W-1:0]     rr_q    [NUM_SETS];

    logic                 r_write;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_wdata;
    logic [2:0]           r_funct3;
    logic [WAY_W-1:0]     vic_way;
    logic                 vic_rr;
    logic [IDX_W-1:0]     fl_set;
    logic [WAY_W-1:0]     fl_way;

    logic                 resp_valid_q;
    logic [31:0]          resp_rdata_q;
    logic                 flush_done_q;

    logic [IDX_W-1:0]     in_set;
    logic [TAG_W-1:0]     in_tag;
    logic [IDX_W-1:0]     r_set;
    logic [TAG_W-1:0]     r_tag;
    logic                 accept;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     vic_sel;
    logic                 vic_sel_rr;
    logic                 fl_last;
    logic                 fl_dirty;
    logic                 fl_step;

    logic                 mem_req_valid_c;
    logic                 mem_req_write_c;
    logic [ADDR_W-1:0]    mem_addr_c;
    logic [LINE_BITS-1:0] mem_wdata_c;

    // Pull the addressed word out of a line and size/extend it for the load.
    function automatic logic [31:0] load_extract(input logic [LINE_BITS-1:0] line,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [2:0] f3);
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        word = line[int'(off >> 2) * 32 +: 32];
        b    = word[int'(off[1:0]) * 8 +: 8];
        h    = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    // Merge store data into a line on the lanes selected by size and offset;
    // any funct3 that is not SB/SH/SW leaves the line untouched.
    function automatic logic [LINE_BITS-1:0] store_merge(input logic [LINE_BITS-1:0] line,
                                                         input logic [OFF_W-1:0] off,
                                                         input logic [2:0] f3,
                                                         input logic [31:0] wdata);
        logic [LINE_BITS-1:0] res;
        int                   base;
        res  = line;
        base = int'(off >> 2) * 32;
        case (f3)
            3'b000:  res[base + int'(off[1:0]) * 8 +: 8] = wdata[7:0];
            3'b001:  res[base + (off[1] ? 16 : 0) +: 16] = wdata[15:0];
            3'b010:  res[base +: 32] = wdata;
            default: res = line;
        endcase
        return res;
    endfunction

    assign in_set = bus.req_addr[OFF_W +: IDX_W];
    assign in_tag = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign r_set  = r_addr[OFF_W +: IDX_W];
    assign r_tag  = r_addr[ADDR_W-1 -: TAG_W];
    assign accept = bus.req_valid && (state == IDLE);

    // Tag lookup for the incoming request; the design guarantees at most one
    // way of a set ever holds a given tag, so the last match is the only one.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[in_set][w] && (tag_q[in_set][w] == in_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: scanning downwards leaves the lowest-index invalid way
    // selected; only when every way is valid does the round-robin pointer
    // decide, and only then may the pointer advance after the fill.
    always_comb begin
        vic_sel    = rr_q[in_set];
        vic_sel_rr = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[in_set][w]) begin
                vic_sel    = WAY_W'(w);
                vic_sel_rr = 1'b0;
            end
        end
    end

    assign fl_last  = (fl_set == IDX_W'(NUM_SETS - 1)) && (fl_way == WAY_W'(NUM_WAYS - 1));
    assign fl_dirty = valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way];
    assign fl_step  = !fl_dirty || bus.mem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory-port decode. The memory request is purely a
    // function of the state, so it drops the cycle after mem_ready moves the
    // FSM on, and reads as all-zero whenever no transfer is in progress.
    always_comb begin
        state_next      = state;
        mem_req_valid_c = 1'b0;
        mem_req_write_c = 1'b0;
        mem_addr_c      = '0;
        mem_wdata_c     = '0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!hit) begin
                        state_next = (valid_q[in_set][vic_sel] && dirty_q[in_set][vic_sel])
                                     ? WRITEBACK : FILL;
                    end
                end else if (bus.flush_req) begin
                    state_next = FLUSH;
                end
            end
            WRITEBACK: begin
                mem_req_valid_c = 1'b1;
                mem_req_write_c = 1'b1;
                mem_addr_c      = {tag_q[r_set][vic_way], r_set, {OFF_W{1'b0}}};
                mem_wdata_c     = data_q[r_set][vic_way];
                if (bus.mem_ready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_req_valid_c = 1'b1;
                mem_addr_c      = {r_tag, r_set, {OFF_W{1'b0}}};
                if (bus.mem_ready) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            FLUSH: begin
                if (fl_dirty) begin
                    mem_req_valid_c = 1'b1;
                    mem_req_write_c = 1'b1;
                    mem_addr_c      = {tag_q[fl_set][fl_way], fl_set, {OFF_W{1'b0}}};
                    mem_wdata_c     = data_q[fl_set][fl_way];
                end
                if (fl_step && fl_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Cache arrays, request capture and the registered response/flush pulses.
    // Hits are answered straight from IDLE; a miss answers from RESPOND, one
    // cycle after the line has been installed, so the data is always read
    // from the array rather than from the memory bus.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            vic_way      <= '0;
            vic_rr       <= 1'b0;
            fl_set       <= '0;
            fl_way       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            flush_done_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_write  <= bus.req_write;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_funct3 <= bus.req_funct3;
                        vic_way  <= vic_sel;
                        vic_rr   <= vic_sel_rr;
                        if (hit) begin
                            resp_valid_q <= 1'b1;
                            if (bus.req_write) begin
                                data_q[in_set][hit_way]  <= store_merge(data_q[in_set][hit_way],
                                                                        bus.req_addr[OFF_W-1:0],
                                                                        bus.req_funct3, bus.req_wdata);
                                dirty_q[in_set][hit_way] <= 1'b1;
                                resp_rdata_q             <= 32'd0;
                            end else begin
                                resp_rdata_q <= load_extract(data_q[in_set][hit_way],
                                                             bus.req_addr[OFF_W-1:0], bus.req_funct3);
                            end
                        end
                    end else if (bus.flush_req) begin
                        fl_set <= '0;
                        fl_way <= '0;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        dirty_q[r_set][vic_way] <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        data_q[r_set][vic_way]  <= r_write
                            ? store_merge(bus.mem_rdata, r_addr[OFF_W-1:0], r_funct3, r_wdata)
                            : bus.mem_rdata;
                        tag_q[r_set][vic_way]   <= r_tag;
                        valid_q[r_set][vic_way] <= 1'b1;
                        dirty_q[r_set][vic_way] <= r_write;
                        if (vic_rr) begin
                            rr_q[r_set] <= vic_way + WAY_W'(1);
                        end
                    end
                end
                RESPOND: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= r_write ? 32'd0
                                            : load_extract(data_q[r_set][vic_way],
                                                           r_addr[OFF_W-1:0], r_funct3);
                end
                FLUSH: begin
                    if (fl_step) begin
                        if (fl_dirty) begin
                            dirty_q[fl_set][fl_way] <= 1'b0;
                        end
                        if (fl_last) begin
                            for (int s = 0; s < NUM_SETS; s++) begin
                                valid_q[s] <= '0;
                                dirty_q[s] <= '0;
                                rr_q[s]    <= '0;
                            end
                            flush_done_q <= 1'b1;
                        end else begin
                            fl_way <= fl_way + WAY_W'(1);
                            if (fl_way == WAY_W'(NUM_WAYS - 1)) begin
                                fl_set <= fl_set + IDX_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.flush_done    = flush_done_q;
    assign bus.mem_req_valid = mem_req_valid_c;
    assign bus.mem_req_write = mem_req_write_c;
    assign bus.mem_addr      = mem_addr_c;
    assign bus.mem_wdata     = mem_wdata_c;
endmodule
